// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
// Request/response bundles and the lane-merge helper.
package dmem_responder_pkg;

  localparam int DMEM_MAX_LATENCY = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } dmem_rsp_entry_t;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle.
// master drives requests, slave returns responses.
interface dmem_responder_if;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr,
    output dmem_rmask,
    output dmem_wmask,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_resp
  );

  modport slave (
    input  dmem_addr,
    input  dmem_rmask,
    input  dmem_wmask,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_resp
  );

endinterface

// File: rtl/dmem_responder_resp_delay_line.sv
// Fixed-depth shift register of response entries.
// Entry pushed every cycle; valid=0 entries are bubbles.
module resp_delay_line
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  dmem_rsp_entry_t in_i,
  output dmem_rsp_entry_t out_o,
  output logic            busy_o
);

  dmem_rsp_entry_t stage_q [DEPTH];

  // shift one stage per cycle; reset flushes in-flight entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_o = stage_q[DEPTH-1];

  // busy whenever any stage holds a live entry
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with backdoor preload.
// Writes land at the accepting edge; reads return LATENCY cycles later.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          LATENCY   = 2,
  parameter int          WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1eceb000,
  localparam int         IW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus,
  input  logic              load_en,
  input  logic [IW-1:0]     load_idx,
  input  logic [31:0]       load_data,
  output logic              busy,
  output logic              err
);

  if (LATENCY < 1 || LATENCY > DMEM_MAX_LATENCY) begin : g_bad_lat
    $error("dmem_responder: LATENCY out of range");
  end

  dmem_req_t       req;
  dmem_rsp_entry_t rsp_in;
  dmem_rsp_entry_t rsp_out;

  logic [31:0] off;
  logic [31:0] widx32;
  logic [IW-1:0] widx;
  logic        rd_req;
  logic        wr_req;
  logic        acc;
  logic        oor;
  logic [31:0] word_now;

  logic [31:0] mem_q [WORDS];

  assign req = '{
    addr:  bus.dmem_addr,
    rmask: bus.dmem_rmask,
    wmask: bus.dmem_wmask,
    wdata: bus.dmem_wdata
  };

  assign off    = req.addr - BASE_ADDR;
  assign widx32 = off >> 2;
  assign widx   = widx32[IW-1:0];
  assign oor    = (req.addr < BASE_ADDR) ||
                  (widx32 >= 32'(WORDS));

  assign rd_req = |req.rmask;
  assign wr_req = |req.wmask;
  assign acc    = rd_req | wr_req;

  assign err = rst_n & acc & (oor | (rd_req & wr_req));

  // word as it stands after a same-edge preload
  assign word_now = (load_en && load_idx == widx) ?
                    load_data : mem_q[widx];

  // preload first so an overlapping request write wins
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
    if (wr_req && !oor) begin
      mem_q[widx] <= lane_merge(word_now, req.wdata, req.wmask);
    end
  end

  // writes and mixed requests respond with zero data
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = acc;
    if (rd_req && !wr_req && !oor) begin
      rsp_in.rdata = word_now;
    end
  end

  resp_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (rsp_in),
    .out_o  (rsp_out),
    .busy_o (busy)
  );

  assign bus.dmem_resp  = rsp_out.valid;
  assign bus.dmem_rdata = rsp_out.valid ? rsp_out.rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder.
// Word-array model plus a queue of scheduled responses.
module tb_dmem_responder;

  localparam int          LAT  = 2;
  localparam int          NW   = 256;
  localparam logic [31:0] BASE = 32'h1eceb000;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [7:0] load_idx;
  logic [31:0] load_data;
  logic       busy;
  logic       err;

  dmem_responder_if bus ();

  dmem_responder #(
    .LATENCY   (LAT),
    .WORDS     (NW),
    .BASE_ADDR (BASE)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (load_data),
    .busy      (busy),
    .err       (err)
  );

  logic [31:0] mm [NW];
  exp_t        q [$];
  int          cyc;
  logic        exp_err;
  int          nvec;
  int          nbad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // per-cycle comparison against the scheduled-response model
  always @(negedge clk) begin
    logic        er;
    logic        eb;
    logic [31:0] ed;
    er = 1'b0;
    eb = 1'b0;
    ed = 32'h0;
    if (q.size() > 0 && q[0].due == cyc) begin
      er = 1'b1;
      ed = q[0].data;
    end
    foreach (q[i]) begin
      if (q[i].acc < cyc) eb = 1'b1;
    end
    chk("resp", {31'h0, bus.dmem_resp}, {31'h0, er});
    chk("rdata", bus.dmem_rdata, ed);
    chk("busy", {31'h0, busy}, {31'h0, eb});
    chk("err", {31'h0, err}, {31'h0, exp_err});
    if (er) void'(q.pop_front());
  end

  task automatic step(input logic [31:0] a, input logic [3:0] rm,
                      input logic [3:0] wm, input logic [31:0] wd,
                      input logic le, input logic [7:0] li,
                      input logic [31:0] ld);
    logic [31:0] off;
    logic [31:0] wi;
    logic        acc;
    logic        oor;
    logic [31:0] data;
    @(posedge clk);
    #1;
    cyc++;
    bus.dmem_addr  = a;
    bus.dmem_rmask = rm;
    bus.dmem_wmask = wm;
    bus.dmem_wdata = wd;
    load_en   = le;
    load_idx  = li;
    load_data = ld;
    acc = (rm != 4'h0) || (wm != 4'h0);
    off = a - BASE;
    wi  = off / 4;
    oor = (a < BASE) || (wi >= NW);
    exp_err = acc && (oor || (rm != 4'h0 && wm != 4'h0));
    if (le) mm[li] = ld;
    if (acc) begin
      data = 32'h0;
      if (!oor) begin
        if (wm != 4'h0) begin
          for (int b = 0; b < 4; b++) begin
            if (wm[b]) mm[wi[7:0]][8*b +: 8] = wd[8*b +: 8];
          end
        end else begin
          data = mm[wi[7:0]];
        end
      end
      q.push_back('{acc: cyc, due: cyc + LAT, data: data});
    end
  endtask

  task automatic idle();
    step(32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic rd(input int i);
    step(BASE + 32'(i) * 4, 4'hf, 4'h0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic load(input int i, input logic [31:0] d);
    step(32'h0, 4'h0, 4'h0, 32'h0, 1'b1, 8'(i), d);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    load_en = 1'b0;
    exp_err = 1'b0;
    q.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic        le;
    logic [7:0]  li;
    int          idx;
    int          k;
    int          s;
    nvec = 0;
    nbad = 0;
    cyc  = 0;
    exp_err = 1'b0;
    rst_n = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    bus.dmem_wdata = 32'h0;
    load_en   = 1'b0;
    load_idx  = 8'h0;
    load_data = 32'h0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;

    for (int i = 0; i < NW; i++) load(i, $urandom);

    // preload then read word 0: response two cycles later
    load(0, 32'hdeadbeef);
    load(2, 32'h22222222);
    load(3, 32'h33333333);
    load(5, 32'h55555555);
    rd(0);
    idle();
    @(negedge clk);
    chk("pin_lat_early", {31'h0, bus.dmem_resp}, 32'h0);
    idle();
    @(negedge clk);
    chk("pin_lat_resp", {31'h0, bus.dmem_resp}, 32'h1);
    chk("pin_preload", bus.dmem_rdata, 32'hdeadbeef);

    // partial write then immediate read
    load(1, 32'haabbccdd);
    step(BASE + 4, 4'h0, 4'b0101, 32'h11223344, 1'b0, 8'h0, 32'h0);
    rd(1);
    idle();
    @(negedge clk);
    chk("pin_wr_rdata0", bus.dmem_rdata, 32'h0);
    idle();
    @(negedge clk);
    chk("pin_merge", bus.dmem_rdata, 32'haa22cc44);
    repeat (3) idle();

    // four back-to-back reads
    rd(0);
    @(negedge clk);
    chk("pin_b2b_busy0", {31'h0, busy}, 32'h0);
    rd(1);
    @(negedge clk);
    chk("pin_b2b_busy1", {31'h0, busy}, 32'h1);
    rd(2);
    @(negedge clk);
    chk("pin_b2b_d0", bus.dmem_rdata, 32'hdeadbeef);
    rd(3);
    @(negedge clk);
    chk("pin_b2b_d1", bus.dmem_rdata, 32'haa22cc44);
    idle();
    @(negedge clk);
    chk("pin_b2b_d2", bus.dmem_rdata, 32'h22222222);
    idle();
    @(negedge clk);
    chk("pin_b2b_d3", bus.dmem_rdata, 32'h33333333);
    chk("pin_b2b_busy5", {31'h0, busy}, 32'h1);
    idle();
    @(negedge clk);
    chk("pin_b2b_idle", {31'h0, busy}, 32'h0);

    // out-of-range read and write
    step(32'h1eceb400, 4'hf, 4'h0, 32'h0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    chk("pin_oor_err", {31'h0, err}, 32'h1);
    step(32'h1eceb400, 4'h0, 4'hf, 32'hffffffff, 1'b0, 8'h0, 32'h0);
    rd(0);
    @(negedge clk);
    chk("pin_oor_rdata", bus.dmem_rdata, 32'h0);
    chk("pin_oor_resp", {31'h0, bus.dmem_resp}, 32'h1);
    idle();
    idle();
    @(negedge clk);
    chk("pin_oor_nowr", bus.dmem_rdata, 32'hdeadbeef);

    // mixed read+write request
    step(BASE + 20, 4'hf, 4'h3, 32'h0000beef, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    chk("pin_mix_err", {31'h0, err}, 32'h1);
    rd(5);
    idle();
    @(negedge clk);
    chk("pin_mix_rdata", bus.dmem_rdata, 32'h0);
    idle();
    @(negedge clk);
    chk("pin_mix_word", bus.dmem_rdata, 32'h5555beef);

    // reset with reads in flight
    repeat (3) idle();
    rd(2);
    rd(3);
    do_reset(2);
    @(negedge clk);
    chk("pin_rst_resp", {31'h0, bus.dmem_resp}, 32'h0);
    rd(0);
    idle();
    @(negedge clk);
    chk("pin_rst_early", {31'h0, bus.dmem_resp}, 32'h0);
    idle();
    @(negedge clk);
    chk("pin_rst_lat", {31'h0, bus.dmem_resp}, 32'h1);
    chk("pin_rst_data", bus.dmem_rdata, 32'hdeadbeef);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      idx = $urandom_range(0, NW - 1);
      a = BASE + 32'(idx) * 4 + 32'($urandom_range(0, 3));
      k = $urandom_range(0, 19);
      if (k == 0) a = BASE + 32'h400 + 32'($urandom_range(0, 255)) * 4;
      if (k == 1) a = BASE - 32'($urandom_range(1, 64));
      if (k == 2) a = 32'hfffffffc;
      s = $urandom_range(0, 9);
      rm = 4'h0;
      wm = 4'h0;
      if (s <= 3) rm = 4'($urandom_range(1, 15));
      if (s >= 4 && s <= 6) wm = 4'($urandom_range(1, 15));
      if (s == 7) begin
        rm = 4'($urandom_range(1, 15));
        wm = 4'($urandom_range(1, 15));
      end
      le = ($urandom_range(0, 4) == 0);
      li = ($urandom_range(0, 1) == 0) ? 8'(idx) : 8'($urandom);
      step(a, rm, wm, $urandom, le, li, $urandom);
    end

    repeat (LAT + 2) idle();
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL expose parameter LATENCY, default 2, meaning the number of cycles from request to response (legal range 1..8).
REQ-002 The block SHALL expose parameter WORDS, default 256, meaning the number of 32-bit words in the backing store.
REQ-003 The block SHALL expose parameter BASE_ADDR, default 32'h1eceb000, meaning the byte address of word 0.
REQ-004 clk  input  1  sole clock; every state element updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 dmem_addr  input  32  request byte address; bits [1:0] are ignored.
REQ-007 dmem_rmask  input  4  read byte mask; nonzero marks a read request.
REQ-008 dmem_wmask  input  4  write byte-lane mask; nonzero marks a write request.
REQ-009 dmem_wdata  input  32  write data, lane-aligned.
REQ-010 dmem_rdata  output  32  read data, valid only while dmem_resp is 1.
REQ-011 dmem_resp  output  1  one-cycle response strobe, one per accepted request.
REQ-012 load_en  input  1  backdoor preload strobe.
REQ-013 load_idx  input  $clog2(WORDS)  preload word index.
REQ-014 load_data  input  32  preload word.
REQ-015 busy  output  1  1 while any request is in flight.
REQ-016 err  output  1  one-cycle strobe on an illegal request.

Function
REQ-017 The block SHALL accept one request on every cycle in which (dmem_rmask | dmem_wmask) != 0; it applies no backpressure.
REQ-018 Word index SHALL be (dmem_addr - BASE_ADDR) >> 2, computed in 32 bits; an index >= WORDS, or BASE_ADDR > dmem_addr, is out of range.
REQ-019 A write SHALL update the byte lanes selected by dmem_wmask in the same edge that accepts the request; unselected lanes are unchanged.
REQ-020 A read SHALL sample the full word at the accepting edge, after any load_en write issued on that same edge; dmem_rdata returns all 4 bytes regardless of rmask.
REQ-021 A read issued one cycle after a write to the same word SHALL return the written data.
REQ-022 dmem_resp SHALL assert exactly LATENCY cycles after the accepting cycle; for writes dmem_rdata SHALL be 0.
REQ-023 Responses SHALL return in request order; back-to-back requests produce back-to-back strobes.
REQ-024 When rmask and wmask are both nonzero, the request SHALL be treated as a write, err SHALL pulse in the accepting cycle, and a response is still returned.
REQ-025 For an out-of-range request, the write SHALL be dropped, read data SHALL be 0, err SHALL pulse, and a response is still returned.
REQ-026 When load_en and an accepted write target the same word on one edge, the request write SHALL win.
REQ-027 busy SHALL equal the OR of the valid bits in the delay line.
REQ-028 When not responding, dmem_rdata SHALL be 32'h0.

Reset
REQ-029 While rst_n = 0, dmem_resp, dmem_rdata, busy, err and every delay-line valid bit SHALL be 0.
REQ-030 Assertion of rst_n SHALL discard in-flight requests with no late responses; writes already applied to the store persist.
REQ-031 The backing store SHALL NOT be reset; contents are defined only by load_en or request writes.
REQ-032 The first request accepted after rst_n deasserts SHALL respond after exactly LATENCY cycles.

Structure
REQ-033 The shared types package SHALL hold the dmem_req_t struct (addr, rmask, wmask, wdata), the dmem_rsp_entry_t struct (valid, rdata), and the constant DMEM_MAX_LATENCY = 8.
REQ-034 The LATENCY-deep shift register of dmem_rsp_entry_t SHALL be the sub-module resp_delay_line, parameterised by depth and reset by rst_n.

Verification
REQ-035 Preload idx 0 = 32'hdeadbeef, then read 32'h1eceb000 at cycle t -> dmem_resp at t+2, rdata = 32'hdeadbeef.
REQ-036 Write 32'h11223344 with wmask 4'b0101 to 32'h1eceb004 over 32'haabbccdd, then read the next cycle -> rdata = 32'haa22cc44.
REQ-037 Issue four consecutive reads of idx 0..3 with LATENCY=3 -> four consecutive strobes in order; busy is high from the first issue until the last response.
REQ-038 Read 32'h1eceb400 with WORDS=256 -> err pulses, response with rdata 0; a write there leaves all words unchanged.
REQ-039 Drop rst_n one cycle after two reads -> no dmem_resp appears; a new read responds at exactly +LATENCY.
REQ-040 rmask=4'hf, wmask=4'h3, wdata=32'h0000beef to idx 5 -> err pulses, lanes 1:0 are written, response rdata = 0.
